alu_sequencer: RTL and testbench

Command-level front end for the 8-bit ALU datapath. Accepts one arithmetic command per valid/ready handshake, expands it into the ALU's 4-bit opcode stream (load A, load B, execute), captures the ALU's registered result and returns it on a valid/ready result port. It is the initiator side of the ALU opcode interface: it drives `alu_inst`/`alu_data`/`ram_addr` and consumes `alu_rtn`.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_sequencer.sv | 115 +++++++++++
 tb/tb_alu_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings between the ALU datapath and its command sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

  localparam int WIDTH = 8;

  // ALU opcode encodings; codes 0x1, 0x2 and 0x9-0xF are reserved and never driven.
  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_LDA_IN  = 4'h3;
  localparam logic [3:0] OP_LDB_IN  = 4'h4;
  localparam logic [3:0] OP_LDA_RAM = 4'h5;
  localparam logic [3:0] OP_LDB_RAM = 4'h6;
  localparam logic [3:0] OP_ADD     = 4'h7;
  localparam logic [3:0] OP_SUB     = 4'h8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Expands one add/sub command into the ALU opcode stream (load A, load B, exec) and returns the result.
// Latency: command handshake at edge N gives res_valid high after edge N+4; one command per 6 cycles.
// Backpressure: cmd_ready only in IDLE; the result is held stable in DONE until res_ready.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH  = alu_pkg::WIDTH,
  parameter int RAM_AW = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_sub,
  input  logic              cmd_a_ram,
  input  logic              cmd_b_ram,
  input  logic [WIDTH-1:0]  cmd_a,
  input  logic [WIDTH-1:0]  cmd_b,
  output logic [3:0]        alu_inst,
  output logic [WIDTH-1:0]  alu_data,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [WIDTH-1:0]  alu_rtn,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_data,
  output logic              res_zero,
  output logic              busy
);

  state_t           state_q, state_d;
  logic             sub_q, a_ram_q, b_ram_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             accept;

  assign accept = cmd_valid && (state_q == S_IDLE);

  // State register; reset abandons any opcode in flight and any pending result.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Command fields are frozen at the handshake so later cmd_* changes cannot disturb the sequence.
  always_ff @(posedge clock) begin
    if (reset) begin
      sub_q   <= 1'b0;
      a_ram_q <= 1'b0;
      b_ram_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (accept) begin
      sub_q   <= cmd_sub;
      a_ram_q <= cmd_a_ram;
      b_ram_q <= cmd_b_ram;
      a_q     <= cmd_a;
      b_q     <= cmd_b;
    end
  end

  // The ALU result register is valid during WAIT; capture it on the edge leaving WAIT.
  always_ff @(posedge clock) begin
    if (reset) begin
      res_data <= '0;
      res_zero <= 1'b0;
    end else if (state_q == S_WAIT) begin
      res_data <= alu_rtn;
      res_zero <= (alu_rtn == '0);
    end
  end

  // Moore decode: next state and all ALU-facing outputs follow from state and latched fields.
  always_comb begin
    state_d   = state_q;
    alu_inst  = OP_NOP;
    alu_data  = '0;
    ram_addr  = '0;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        alu_inst = a_ram_q ? OP_LDA_RAM : OP_LDA_IN;
        alu_data = a_q;
        ram_addr = a_q[RAM_AW-1:0];
        state_d  = S_LOAD_B;
      end
      S_LOAD_B: begin
        alu_inst = b_ram_q ? OP_LDB_RAM : OP_LDB_IN;
        alu_data = b_q;
        ram_addr = b_q[RAM_AW-1:0];
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        alu_inst = sub_q ? OP_SUB : OP_ADD;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and operand RAM attached.
// Latency: checks exact per-cycle opcode stream and result timing.
// Backpressure: exercises res_ready low with a pending command, and reset mid-sequence.
module tb_alu_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_sub, cmd_a_ram, cmd_b_ram;
  logic [7:0] cmd_a, cmd_b;
  logic [3:0] alu_inst;
  logic [7:0] alu_data;
  logic [3:0] ram_addr;
  logic [7:0] alu_rtn;
  logic       res_valid, res_ready, res_zero, busy;
  logic [7:0] res_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Behavioural ALU: registers never reset, start with junk so stale state would show up.
  logic [7:0] alu_a = 8'hAA;
  logic [7:0] alu_b = 8'h55;
  logic [7:0] alu_r = 8'hC3;
  logic [7:0] ram [16];
  logic [7:0] ram_in;

  assign ram_in  = ram[ram_addr];
  assign alu_rtn = alu_r;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    case (alu_inst)
      4'h3: alu_a <= alu_data;
      4'h5: alu_a <= ram_in;
      4'h4: alu_b <= alu_data;
      4'h6: alu_b <= ram_in;
      4'h7: alu_r <= alu_a + alu_b;
      4'h8: alu_r <= alu_a - alu_b;
      default: ;
    endcase
  end

  alu_sequencer #(.WIDTH(8), .RAM_AW(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sub   (cmd_sub),
    .cmd_a_ram (cmd_a_ram),
    .cmd_b_ram (cmd_b_ram),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_inst  (alu_inst),
    .alu_data  (alu_data),
    .ram_addr  (ram_addr),
    .alu_rtn   (alu_rtn),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_zero  (res_zero),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue a command from IDLE and follow it cycle by cycle up to DONE (left in DONE).
  task automatic do_cmd(input string tag, input logic sub, input logic ar, input logic br,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] r);
    logic [3:0] exp_lda, exp_ldb, exp_ex;
    exp_lda = ar ? 4'h5 : 4'h3;
    exp_ldb = br ? 4'h6 : 4'h4;
    exp_ex  = sub ? 4'h8 : 4'h7;
    cmd_sub = sub; cmd_a_ram = ar; cmd_b_ram = br; cmd_a = a; cmd_b = b;
    cmd_valid = 1'b1;
    check({tag, ".idle_ready"}, cmd_ready, 1);
    check({tag, ".idle_nop"}, alu_inst, 0);
    step();
    // Scramble the command inputs: the latched copy must be used.
    cmd_valid = 1'b0; cmd_a = ~a; cmd_b = ~b; cmd_sub = ~sub; cmd_a_ram = ~ar; cmd_b_ram = ~br;
    check({tag, ".lda_inst"}, alu_inst, exp_lda);
    check({tag, ".lda_data"}, alu_data, a);
    check({tag, ".lda_addr"}, ram_addr, a[3:0]);
    check({tag, ".lda_busy"}, busy, 1);
    check({tag, ".lda_ready"}, cmd_ready, 0);
    step();
    check({tag, ".ldb_inst"}, alu_inst, exp_ldb);
    check({tag, ".ldb_data"}, alu_data, b);
    check({tag, ".ldb_addr"}, ram_addr, b[3:0]);
    step();
    check({tag, ".exec_inst"}, alu_inst, exp_ex);
    check({tag, ".exec_data"}, alu_data, 0);
    check({tag, ".exec_addr"}, ram_addr, 0);
    step();
    check({tag, ".wait_inst"}, alu_inst, 0);
    check({tag, ".wait_valid"}, res_valid, 0);
    step();
    check({tag, ".done_valid"}, res_valid, 1);
    check({tag, ".done_data"}, res_data, r);
    check({tag, ".done_zero"}, res_zero, (r == 8'h00) ? 1 : 0);
    check({tag, ".done_inst"}, alu_inst, 0);
    check({tag, ".done_busy"}, busy, 1);
  endtask

  task automatic to_idle(input string tag);
    step();
    check({tag, ".ret_valid"}, res_valid, 0);
    check({tag, ".ret_ready"}, cmd_ready, 1);
    check({tag, ".ret_busy"}, busy, 0);
  endtask

  int t_prev;
  int t_done;
  logic [7:0] seq_a [3];
  logic [7:0] seq_b [3];
  logic [7:0] seq_r [3];

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_sub = 1'b0; cmd_a_ram = 1'b0; cmd_b_ram = 1'b0;
    cmd_a = 8'h00; cmd_b = 8'h00; res_ready = 1'b1;
    for (int i = 0; i < 16; i++) ram[i] = 8'(i * 17 + 1);
    ram[3] = 8'h20;
    ram[9] = 8'h0F;
    step(); step();
    reset = 1'b0;

    check("rst.cmd_ready", cmd_ready, 1);
    check("rst.alu_inst", alu_inst, 0);
    check("rst.alu_data", alu_data, 0);
    check("rst.ram_addr", ram_addr, 0);
    check("rst.res_valid", res_valid, 0);
    check("rst.res_data", res_data, 0);
    check("rst.res_zero", res_zero, 0);
    check("rst.busy", busy, 0);

    // res_ready high with nothing pending must change nothing.
    step();
    check("idle.res_ready_noop", res_valid, 0);

    do_cmd("add", 1'b0, 1'b0, 1'b0, 8'h12, 8'h34, 8'h46);
    to_idle("add");
    do_cmd("subwrap", 1'b1, 1'b0, 1'b0, 8'h05, 8'h07, 8'hFE);
    to_idle("subwrap");
    do_cmd("subzero", 1'b1, 1'b0, 1'b0, 8'h80, 8'h80, 8'h00);
    to_idle("subzero");
    do_cmd("ram", 1'b0, 1'b1, 1'b1, 8'h03, 8'h09, 8'h2F);
    to_idle("ram");

    // Backpressure: hold result while a new command waits on cmd_valid.
    res_ready = 1'b0;
    do_cmd("bp1", 1'b0, 1'b0, 1'b0, 8'h10, 8'h01, 8'h11);
    cmd_valid = 1'b1; cmd_sub = 1'b0; cmd_a_ram = 1'b0; cmd_b_ram = 1'b0;
    cmd_a = 8'h40; cmd_b = 8'h02;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp.hold_valid", res_valid, 1);
      check("bp.hold_data", res_data, 8'h11);
      check("bp.hold_ready", cmd_ready, 0);
      check("bp.hold_inst", alu_inst, 0);
    end
    res_ready = 1'b1;
    to_idle("bp");
    do_cmd("bp2", 1'b0, 1'b0, 1'b0, 8'h40, 8'h02, 8'h42);
    to_idle("bp2");

    // Reset during EXEC.
    cmd_valid = 1'b1; cmd_sub = 1'b0; cmd_a_ram = 1'b0; cmd_b_ram = 1'b0;
    cmd_a = 8'h99; cmd_b = 8'h11;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    check("rexec.in_exec", alu_inst, 4'h7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rexec.inst", alu_inst, 0);
    check("rexec.valid", res_valid, 0);
    check("rexec.ready", cmd_ready, 1);
    check("rexec.busy", busy, 0);
    check("rexec.res_data", res_data, 0);
    step();
    check("rexec.stays_idle", busy, 0);
    do_cmd("postrst", 1'b1, 1'b0, 1'b0, 8'h01, 8'h02, 8'hFF);
    to_idle("postrst");

    // Back-to-back with res_ready high: results 6 cycles apart.
    seq_a[0] = 8'h01; seq_b[0] = 8'h01; seq_r[0] = 8'h02;
    seq_a[1] = 8'hF0; seq_b[1] = 8'h20; seq_r[1] = 8'h10;
    seq_a[2] = 8'h33; seq_b[2] = 8'h11; seq_r[2] = 8'h44;
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      do_cmd("b2b", 1'b0, 1'b0, 1'b0, seq_a[k], seq_b[k], seq_r[k]);
      t_done = cyc;
      if (k > 0) check("b2b.spacing", t_done - t_prev, 6);
      t_prev = t_done;
      step();
    end
    check("b2b.final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
